qam_tx_frame_scheduler: RTL and testbench
=========================================

# qam_tx_frame_scheduler

Frame-level sequencer for the QAM-16 transmit datapath, running in the 41-clock domain that feeds the zero padder and shaping filter. Builds each frame as a pilot section, a data section and a filter flush tail. Upsamples every symbol slot by OSR, so each pilot or data symbol is followed by OSR-1 zero-pad samples. Drives the zero-pad select, filter shift enable and carrier index, and pulls symbols from the mapper through a valid/ready handshake.

## Interface
- WID_COUNT, 4, width of sel_carrier; the index wraps modulo 2^WID_COUNT.
- N_PILOT, 4, pilot symbols per frame; must be 1 or more.
- N_DATA, 32, data symbols per frame; must be 1 or more.
- OSR, 4, samples per symbol; must be 2 or more.
- N_TAIL, 16, zero samples appended to flush the filter; must be 1 or more.

- clk  in  1  clock (41-clock domain).
- rst_clk  in  1  reset, asynchronous, active-high.
- start  in  1  frame request; sampled only in IDLE.
- sym_valid  in  1  mapper holds a data symbol.
- sym_ready  out  1  mapper pop strobe: sym_valid and sym_ready high together consume one symbol.
- filter_ready  in  1  filter accepts a sample this cycle; low stalls the schedule.
- sel_pilot  out  1  current sample is the pilot symbol.
- sel_zero_pad  out  1  current sample is a zero insert.
- ce_shift  out  1  filter shift enable; high exactly when a sample advances.
- sel_carrier  out  WID_COUNT  symbol index within the frame.
- busy  out  1  high in every state except IDLE.
- underrun  out  1  one-cycle pulse when a data slot first stalls on sym_valid=0.
- frame_done  out  1  one-cycle pulse after the last tail sample.

## Operation
- States:
  - IDLE: start=1 loads PILOT and clears ph, sym_cnt, tail_cnt and sel_carrier.
  - PILOT: runs N_PILOT symbol slots, then goes to DATA.
  - DATA: runs N_DATA symbol slots, then goes to TAIL.
  - TAIL: runs N_TAIL samples, then goes to IDLE with frame_done=1.
- advance = busy & filter_ready & !(DATA & ph==0 & !sym_valid). ce_shift = advance.
- Counters move only on advance:
  - ph counts 0..OSR-1 and wraps.
  - sym_cnt counts symbols in the current section.
  - tail_cnt counts 0..N_TAIL-1.
- Symbol slot (ph==0):
  - PILOT: sel_pilot=1, sel_zero_pad=0.
  - DATA: sel_pilot=0, sel_zero_pad=0, sym_ready=filter_ready & sym_valid.
- ph!=0 in PILOT or DATA: sel_zero_pad=1.
- TAIL: sel_zero_pad=1 on every sample.
- In IDLE: sel_pilot=0, sel_zero_pad=0, ce_shift=0, sym_ready=0.
- sym_ready is never high outside DATA & ph==0.
- sel_carrier increments on the advance of each symbol slot, pilot and data alike. It wraps 2^WID_COUNT-1 -> 0 and holds through TAIL.
- Section change: after sym_cnt reaches N-1 and ph==OSR-1 advances, ph resets to 0 and the state moves on.
- Underrun: a starved DATA slot holds all counters; it does not drop or skip a symbol.
  - underrun pulses once on the first starved cycle.
  - underrun re-arms only after that slot advances.
- start is ignored while busy. frame_done and a new start may coincide: start accepted in the IDLE cycle that shows frame_done.

## Timing
- Reset: state=IDLE, all counters 0, every output 0 (sel_carrier=0).
- Reset mid-frame: immediate return to IDLE. No frame_done; the mapper handshake is dropped.
- State and counters are registered. sel_pilot, sel_zero_pad and sel_carrier decode registered state only.
- sym_ready and ce_shift also depend combinationally on filter_ready and sym_valid.
- start high at edge k makes busy high from edge k+1; the first sample slot is cycle k+1.
- With no stalls, ce_shift is high for exactly (N_PILOT+N_DATA)*OSR + N_TAIL consecutive cycles.
- frame_done is registered and high the cycle after the last ce_shift.
- filter_ready=0 stalls every state: counters hold, ce_shift=0, and select outputs stay stable.

## Test plan
- Defaults, start pulse at cycle 0, filter_ready=1, sym_valid=1 -> busy cycles 1..160 and 160 ce_shift pulses.
  - sel_pilot high on cycles 1, 5, 9, 13.
  - 32 sym_ready pulses, the first on cycle 17.
  - sel_zero_pad high on 124 cycles.
  - frame_done on cycle 161.
- sel_carrier wrap (WID_COUNT=4) -> sequence 0..15, 0..15, 0..3 across the 36 symbol slots; holds at 4 through TAIL.
- sym_valid low for 5 cycles at the 3rd data slot -> underrun single pulse; no ce_shift during the gap; counters frozen; the frame stretches by exactly 5 cycles; sym_ready count still 32.
- filter_ready toggled 1,0 every cycle -> 160 ce_shift pulses over 320 busy cycles; the sample and select order is identical to the unstalled frame.
- start held high continuously -> back-to-back frames. frame_done coincides with IDLE for one cycle, and the next PILOT begins the following cycle.
- rst_clk asserted mid-DATA for 1 cycle, asynchronously -> all outputs 0 immediately, no frame_done. A new start then yields a full 160-sample frame.

Source files
------------

// File: rtl/qam_tx_frame_scheduler.sv
// Frame sequencer for the QAM-16 transmit path: pilot section, data section and filter flush
// tail, with every symbol slot upsampled by OSR and the mapper pulled through valid/ready.
module qam_tx_frame_scheduler #(
   parameter int WID_COUNT = 4,
   parameter int N_PILOT   = 4,
   parameter int N_DATA    = 32,
   parameter int OSR       = 4,
   parameter int N_TAIL    = 16
) (
   input  logic                 clk,
   input  logic                 rst_clk,
   input  logic                 start,
   input  logic                 sym_valid,
   output logic                 sym_ready,
   input  logic                 filter_ready,
   output logic                 sel_pilot,
   output logic                 sel_zero_pad,
   output logic                 ce_shift,
   output logic [WID_COUNT-1:0] sel_carrier,
   output logic                 busy,
   output logic                 underrun,
   output logic                 frame_done
);

   localparam int N_MAX  = (N_PILOT > N_DATA) ? N_PILOT : N_DATA;
   localparam int PH_W   = (OSR > 2) ? $clog2(OSR) : 1;
   localparam int CNT_W  = $clog2(N_MAX + 1);
   localparam int TAIL_W = $clog2(N_TAIL + 1);

   localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(OSR - 1);
   localparam logic [CNT_W-1:0]  PILOT_LAST = CNT_W'(N_PILOT - 1);
   localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(N_DATA - 1);
   localparam logic [TAIL_W-1:0] TAIL_LAST  = TAIL_W'(N_TAIL - 1);

   typedef enum logic [1:0] {S_IDLE, S_PILOT, S_DATA, S_TAIL} state_t;

   state_t               state_q, state_d;
   logic [PH_W-1:0]      ph_q, ph_d;
   logic [CNT_W-1:0]     sym_cnt_q, sym_cnt_d;
   logic [TAIL_W-1:0]    tail_cnt_q, tail_cnt_d;
   logic [WID_COUNT-1:0] carrier_q, carrier_d;
   logic                 ur_seen_q, ur_seen_d;
   logic                 frame_done_q, frame_done_d;

   logic slot;
   logic starved;
   logic advance;
   logic sym_last;

   always_ff @(posedge clk or posedge rst_clk) begin
      if (rst_clk) begin
         state_q      <= S_IDLE;
         ph_q         <= '0;
         sym_cnt_q    <= '0;
         tail_cnt_q   <= '0;
         carrier_q    <= '0;
         ur_seen_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ph_q         <= ph_d;
         sym_cnt_q    <= sym_cnt_d;
         tail_cnt_q   <= tail_cnt_d;
         carrier_q    <= carrier_d;
         ur_seen_q    <= ur_seen_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ph_d         = ph_q;
      sym_cnt_d    = sym_cnt_q;
      tail_cnt_d   = tail_cnt_q;
      carrier_d    = carrier_q;
      ur_seen_d    = ur_seen_q;
      frame_done_d = 1'b0;

      slot     = (ph_q == '0);
      // A data slot with nothing from the mapper freezes the whole schedule, never skips.
      starved  = (state_q == S_DATA) && slot && !sym_valid;
      busy     = (state_q != S_IDLE);
      advance  = busy && filter_ready && !starved;
      sym_last = (state_q == S_PILOT) ? (sym_cnt_q == PILOT_LAST) : (sym_cnt_q == DATA_LAST);

      ce_shift     = advance;
      sym_ready    = (state_q == S_DATA) && slot && filter_ready && sym_valid;
      sel_pilot    = (state_q == S_PILOT) && slot;
      sel_zero_pad = (state_q == S_TAIL) ||
                     (((state_q == S_PILOT) || (state_q == S_DATA)) && !slot);
      sel_carrier  = carrier_q;
      underrun     = starved && !ur_seen_q;
      frame_done   = frame_done_q;

      if (starved) begin
         ur_seen_d = 1'b1;
      end else if (advance) begin
         ur_seen_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_PILOT;
               ph_d       = '0;
               sym_cnt_d  = '0;
               tail_cnt_d = '0;
               carrier_d  = '0;
               ur_seen_d  = 1'b0;
            end
         end
         S_PILOT, S_DATA: begin
            if (advance) begin
               if (slot) begin
                  carrier_d = carrier_q + WID_COUNT'(1);
               end
               if (ph_q == PH_LAST) begin
                  ph_d = '0;
                  if (sym_last) begin
                     sym_cnt_d = '0;
                     state_d   = (state_q == S_PILOT) ? S_DATA : S_TAIL;
                  end else begin
                     sym_cnt_d = sym_cnt_q + CNT_W'(1);
                  end
               end else begin
                  ph_d = ph_q + PH_W'(1);
               end
            end
         end
         S_TAIL: begin
            if (advance) begin
               if (tail_cnt_q == TAIL_LAST) begin
                  tail_cnt_d   = '0;
                  state_d      = S_IDLE;
                  frame_done_d = 1'b1;
               end else begin
                  tail_cnt_d = tail_cnt_q + TAIL_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_qam_tx_frame_scheduler.sv
// Directed bench for qam_tx_frame_scheduler with default parameters (160-sample frames).
module tb_qam_tx_frame_scheduler;

   logic       clk = 1'b0;
   logic       rst_clk = 1'b1;
   logic       start = 1'b0;
   logic       sym_valid = 1'b1;
   logic       filter_ready = 1'b1;
   logic       sym_ready, sel_pilot, sel_zero_pad, ce_shift, busy, underrun, frame_done;
   logic [3:0] sel_carrier;

   qam_tx_frame_scheduler #(
      .WID_COUNT(4), .N_PILOT(4), .N_DATA(32), .OSR(4), .N_TAIL(16)
   ) dut (
      .clk(clk), .rst_clk(rst_clk), .start(start), .sym_valid(sym_valid),
      .sym_ready(sym_ready), .filter_ready(filter_ready), .sel_pilot(sel_pilot),
      .sel_zero_pad(sel_zero_pad), .ce_shift(ce_shift), .sel_carrier(sel_carrier),
      .busy(busy), .underrun(underrun), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   int busy_n, ce_n, zp_n, sr_n, ur_n, fd_n, fd_cyc, first_sr, ur_cyc, stall_bad;
   int         pilot_cyc[$];
   logic [5:0] order[$];
   logic [5:0] ref_order[$];
   logic [3:0] car[$];
   logic [3:0] last_busy_car;
   logic       busy_h[512];
   logic       pilot_h[512];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // mode 0: plain frame, 1: sym_valid gap at 3rd data slot, 2: filter_ready 1/0 toggle,
   // 3: start held high, 4: start never asserted
   task automatic run(input int mode, input int ncyc);
      busy_n = 0; ce_n = 0; zp_n = 0; sr_n = 0; ur_n = 0; fd_n = 0;
      fd_cyc = -1; first_sr = -1; ur_cyc = -1; stall_bad = 0;
      pilot_cyc.delete(); order.delete(); car.delete();
      last_busy_car = 4'hx;
      for (int c = 0; c < ncyc; c++) begin
         start        = (mode == 3) ? 1'b1 : ((mode != 4) && (c == 0));
         sym_valid    = (mode == 1 && c >= 25 && c <= 29) ? 1'b0 : 1'b1;
         filter_ready = (mode == 2) ? (c % 2 == 0) : 1'b1;
         @(negedge clk);
         busy_h[c]  = busy;
         pilot_h[c] = sel_pilot;
         if (busy) begin
            busy_n++;
            last_busy_car = sel_carrier;
         end
         if (ce_shift) begin
            ce_n++;
            order.push_back({sel_pilot, sel_zero_pad, sel_carrier});
            if (!sel_zero_pad) car.push_back(sel_carrier);
         end
         if (sel_pilot) pilot_cyc.push_back(c);
         if (sel_zero_pad) zp_n++;
         if (sym_ready) begin
            if (sr_n == 0) first_sr = c;
            sr_n++;
         end
         if (underrun) begin
            if (ur_n == 0) ur_cyc = c;
            ur_n++;
         end
         if (frame_done) begin
            if (fd_n == 0) fd_cyc = c;
            fd_n++;
         end
         if (mode == 1 && c >= 25 && c <= 29 && (ce_shift || sel_carrier != 4'd6 || sel_zero_pad))
            stall_bad++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_ce", ce_shift, 0);
      chk("rst_sym_ready", sym_ready, 0);
      chk("rst_sel_pilot", sel_pilot, 0);
      chk("rst_zero_pad", sel_zero_pad, 0);
      chk("rst_carrier", sel_carrier, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_frame_done", frame_done, 0);
      #10 rst_clk = 1'b0;
      @(posedge clk);
      #1;

      run(0, 163);
      chk("f0_busy_cycles", busy_n, 160);
      chk("f0_ce_pulses", ce_n, 160);
      chk("f0_pilot_count", pilot_cyc.size(), 4);
      for (int i = 0; i < 4 && i < pilot_cyc.size(); i++)
         chk($sformatf("f0_pilot_cyc%0d", i), pilot_cyc[i], 1 + 4 * i);
      chk("f0_sym_ready_count", sr_n, 32);
      chk("f0_first_sym_ready", first_sr, 17);
      chk("f0_zero_pad_cycles", zp_n, 124);
      chk("f0_frame_done_cyc", fd_cyc, 161);
      chk("f0_frame_done_count", fd_n, 1);
      chk("f0_underrun_count", ur_n, 0);
      chk("f0_slot_count", car.size(), 36);
      for (int i = 0; i < 36 && i < car.size(); i++)
         chk($sformatf("f0_carrier_slot%0d", i), car[i], i % 16);
      chk("f0_tail_carrier", last_busy_car, 4);
      ref_order = order;

      run(1, 168);
      chk("ur_pulse_count", ur_n, 1);
      chk("ur_pulse_cyc", ur_cyc, 25);
      chk("ur_gap_frozen", stall_bad, 0);
      chk("ur_ce_pulses", ce_n, 160);
      chk("ur_sym_ready_count", sr_n, 32);
      chk("ur_busy_cycles", busy_n, 165);
      chk("ur_frame_done_cyc", fd_cyc, 166);

      run(2, 323);
      chk("fr_busy_cycles", busy_n, 320);
      chk("fr_ce_pulses", ce_n, 160);
      chk("fr_sym_ready_count", sr_n, 32);
      chk("fr_frame_done_cyc", fd_cyc, 321);
      begin
         int diff = 0;
         if (order.size() != ref_order.size()) diff = 1;
         else for (int i = 0; i < order.size(); i++) if (order[i] !== ref_order[i]) diff++;
         chk("fr_sample_order_diffs", diff, 0);
      end

      run(0, 41);
      chk("rst_mid_busy_before", busy, 1);
      start = 1'b0;
      rst_clk = 1'b1;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ce", ce_shift, 0);
      chk("rst_mid_sym_ready", sym_ready, 0);
      chk("rst_mid_zero_pad", sel_zero_pad, 0);
      chk("rst_mid_pilot", sel_pilot, 0);
      chk("rst_mid_carrier", sel_carrier, 0);
      chk("rst_mid_frame_done", frame_done, 0);
      #2 rst_clk = 1'b0;
      @(posedge clk);
      #1;
      run(4, 10);
      chk("rst_mid_no_frame_done", fd_n, 0);
      chk("rst_mid_stays_idle", busy_n, 0);
      run(0, 163);
      chk("rst_new_ce_pulses", ce_n, 160);
      chk("rst_new_frame_done_cyc", fd_cyc, 161);

      run(3, 170);
      chk("b2b_frame_done_cyc", fd_cyc, 161);
      chk("b2b_idle_at_done", busy_h[161], 0);
      chk("b2b_busy_next", busy_h[162], 1);
      chk("b2b_pilot_next", pilot_h[162], 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
